// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Handshaked, multi-cycle execution unit for the core's ALU opcode set.
// It sits between decode/issue and writeback. It accepts one
// {alu_ctrl, srcA, srcB} request at a time and returns a registered result
// together with the NZCV flags.
// MUL and DIV are iterative and take WIDTH cycles. Every other opcode
// completes in a single cycle.
//
// Ports
//   clk        in   1       single clock, rising edge
//   rst        in   1       asynchronous, active-high reset
//   in_valid   in   1       request valid
//   in_ready   out  1       unit can accept a request (IDLE only)
//   alu_ctrl   in   CTRL_W  opcode: 1 ADD, 2 SUB, 3 MUL, 4 MOV, 5 DIV,
//                           6 LNUM, 9 AND, 10 OR, 11 XOR, 12 NOT
//   srcA       in   WIDTH   operand A
//   srcB       in   WIDTH   operand B (ignored by MOV and NOT)
//   out_valid  out  1       result/flags valid (DONE only)
//   out_ready  in   1       consumer accepts result
//   result     out  WIDTH   registered result
//   alu_flags  out  4       registered {N,Z,C,V}
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  srcA,
    input  logic [WIDTH-1:0]  srcB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [3:0]        alu_flags
);

    localparam int CNT_W  = $clog2(WIDTH);
    localparam int NBYTES = WIDTH / 8;

    localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] OP_MUL  = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] OP_MOV  = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] OP_DIV  = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] OP_LNUM = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(9);
    localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(10);
    localparam logic [CTRL_W-1:0] OP_XOR  = CTRL_W'(11);
    localparam logic [CTRL_W-1:0] OP_NOT  = CTRL_W'(12);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state;
    state_t state_next;

    // Latched operands. acc_hi/acc_lo are shared by both iterative ops.
    // MUL uses them as {partial product, multiplier}.
    // DIV uses them as {remainder, dividend/quotient}.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CNT_W-1:0] iter;
    logic             last_iter;

    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] byte_k;
    logic [7:0]       lnum_byte;
    logic [WIDTH-1:0] simple_res;
    logic             simple_c;
    logic             simple_v;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] div_hi_next;
    logic [WIDTH-1:0] div_lo_next;

    assign last_iter = (iter == CNT_W'(WIDTH - 1));

    // Single-cycle operations are computed straight from the request inputs
    // so that the result can be registered on the accepting edge.
    // In this block, bit WIDTH of sub_full is the borrow out of A-B.
    always_comb begin
        add_full   = {1'b0, srcA} + {1'b0, srcB};
        sub_full   = {1'b0, srcA} - {1'b0, srcB};
        byte_k     = (srcB - WIDTH'(1)) % WIDTH'(NBYTES);
        lnum_byte  = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_k == WIDTH'(i)) begin
                lnum_byte = srcA[8*i +: 8];
            end
        end
        simple_res = '0;
        simple_c   = 1'b0;
        simple_v   = 1'b0;
        case (alu_ctrl)
            OP_ADD: begin
                simple_res = add_full[WIDTH-1:0];
                simple_c   = add_full[WIDTH];
                simple_v   = (srcA[WIDTH-1] == srcB[WIDTH-1]) &&
                             (add_full[WIDTH-1] != srcA[WIDTH-1]);
            end
            OP_SUB: begin
                simple_res = sub_full[WIDTH-1:0];
                simple_c   = ~sub_full[WIDTH];
                simple_v   = (srcA[WIDTH-1] != srcB[WIDTH-1]) &&
                             (sub_full[WIDTH-1] != srcA[WIDTH-1]);
            end
            OP_MOV:  simple_res = srcA;
            OP_LNUM: simple_res = {{(WIDTH-8){1'b0}}, lnum_byte};
            OP_AND:  simple_res = srcA & srcB;
            OP_OR:   simple_res = srcA | srcB;
            OP_XOR:  simple_res = srcA ^ srcB;
            OP_NOT:  simple_res = ~srcA;
            default: simple_res = '0;
        endcase
    end

    // One step of each iterative algorithm.
    // MUL is shift-add: conditionally add A into the top half, then shift the
    // whole {acc_hi, acc_lo} pair right by one bit.
    // DIV is restoring: shift the next dividend bit into the remainder and
    // subtract B. A clear top bit of the trial difference means there was no
    // borrow, so the difference is kept and the quotient bit is 1.
    always_comb begin
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : '0);
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
        div_trial   = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, op_b};
        if (!div_trial[WIDTH]) begin
            div_hi_next = div_trial[WIDTH-1:0];
            div_lo_next = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            div_hi_next = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
            div_lo_next = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // Requests are only looked at in IDLE. DONE waits for the consumer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (alu_ctrl == OP_MUL) begin
                        state_next = MUL;
                    end else if (alu_ctrl == OP_DIV) begin
                        state_next = DIV;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            MUL:     if (last_iter) state_next = DONE;
            DIV:     if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are pure decodes of the state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath registers.
    // On the last iteration edge, the stepped values are written straight to
    // result, so MUL/DIV finish after exactly WIDTH iteration cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            iter      <= '0;
            result    <= '0;
            alu_flags <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a   <= srcA;
                        op_b   <= srcB;
                        iter   <= '0;
                        acc_hi <= '0;
                        if (alu_ctrl == OP_MUL) begin
                            acc_lo <= srcB;
                        end else if (alu_ctrl == OP_DIV) begin
                            acc_lo <= srcA;
                        end else begin
                            result    <= simple_res;
                            alu_flags <= {simple_res[WIDTH-1], (simple_res == '0),
                                          simple_c, simple_v};
                        end
                    end
                end
                MUL: begin
                    acc_hi <= mul_hi_next;
                    acc_lo <= mul_lo_next;
                    iter   <= iter + CNT_W'(1);
                    if (last_iter) begin
                        result    <= mul_lo_next;
                        alu_flags <= {mul_lo_next[WIDTH-1], (mul_lo_next == '0),
                                      1'b0, (mul_hi_next != '0)};
                    end
                end
                DIV: begin
                    acc_hi <= div_hi_next;
                    acc_lo <= div_lo_next;
                    iter   <= iter + CNT_W'(1);
                    if (last_iter) begin
                        if (op_b == '0) begin
                            result    <= '1;
                            alu_flags <= 4'b1001;
                        end else begin
                            result    <= div_lo_next;
                            alu_flags <= {div_lo_next[WIDTH-1], (div_lo_next == '0),
                                          1'b0, 1'b0};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed testbench for alu_exec_unit (WIDTH=32).
// Each scenario lives in its own test_* task, and the tasks are called in
// sequence. All expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_ctrl;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  alu_flags;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    alu_exec_unit #(.WIDTH(32), .CTRL_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .srcA      (srcA),
        .srcB      (srcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .alu_flags (alu_flags)
    );

    always #5 clk = ~clk;

    // Present a request at a falling edge and hold it across one rising edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        alu_ctrl = op;
        srcA     = a;
        srcB     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Latency counted in rising edges, including the accepting edge.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctrl  = '0;
        srcA      = '0;
        srcB      = '0;
        @(posedge clk);
        #1;
        check_count++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        else pass_count++;
        check_count++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        else pass_count++;
        check_count++;
        if (result !== 32'h0) $display("[TB] FAIL reset_result: got %h expected 00000000", result);
        else pass_count++;
        check_count++;
        if (alu_flags !== 4'b0000) $display("[TB] FAIL reset_flags: got %b expected 0000", alu_flags);
        else pass_count++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Shared body for the vector-table tests.
    task automatic run_vectors(input string tag, input vec_t vecs[$], input int exp_lat);
        int lat;
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat);
            check_count++;
            if (lat !== exp_lat)
                $display("[TB] FAIL %s_latency[%0d]: got %0d expected %0d", tag, i, lat, exp_lat);
            else pass_count++;
            check_count++;
            if (result !== vecs[i].res)
                $display("[TB] FAIL %s_result[%0d] op=%0d: got %h expected %h",
                         tag, i, vecs[i].op, result, vecs[i].res);
            else pass_count++;
            check_count++;
            if (alu_flags !== vecs[i].fl)
                $display("[TB] FAIL %s_flags[%0d] op=%0d: got %b expected %b",
                         tag, i, vecs[i].op, alu_flags, vecs[i].fl);
            else pass_count++;
            release_result();
        end
    endtask

    task automatic test_simple_ops();
        vec_t v[$];
        v.push_back('{5'd1,  32'h00000001, 32'h00000005, 32'h00000006, 4'b0000});
        v.push_back('{5'd2,  32'h00000002, 32'h00000001, 32'h00000001, 4'b0010});
        v.push_back('{5'd2,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000});
        v.push_back('{5'd1,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001});
        v.push_back('{5'd1,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110});
        v.push_back('{5'd2,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011});
        v.push_back('{5'd4,  32'h12345678, 32'hDEADBEEF, 32'h12345678, 4'b0000});
        v.push_back('{5'd12, 32'h00000000, 32'h00000055, 32'hFFFFFFFF, 4'b1000});
        v.push_back('{5'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000});
        v.push_back('{5'd10, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0FFF0FFF, 4'b0000});
        v.push_back('{5'd11, 32'h5555AAAA, 32'h5555AAAA, 32'h00000000, 4'b0100});
        run_vectors("simple", v, 1);
    endtask

    task automatic test_lnum();
        vec_t v[$];
        v.push_back('{5'd6, 32'h080B0A02, 32'h00000002, 32'h0000000A, 4'b0000});
        v.push_back('{5'd6, 32'h080B0A02, 32'h00000004, 32'h00000008, 4'b0000});
        v.push_back('{5'd6, 32'h080B0A02, 32'h00000001, 32'h00000002, 4'b0000});
        v.push_back('{5'd6, 32'h080B0A02, 32'h00000000, 32'h00000008, 4'b0000});
        v.push_back('{5'd6, 32'h080B0A02, 32'h00000003, 32'h0000000B, 4'b0000});
        run_vectors("lnum", v, 1);
    endtask

    task automatic test_undefined();
        vec_t v[$];
        v.push_back('{5'd7,  32'h00000005, 32'h00000005, 32'h00000000, 4'b0100});
        v.push_back('{5'd0,  32'h00000009, 32'h00000009, 32'h00000000, 4'b0100});
        v.push_back('{5'd31, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0100});
        run_vectors("undef", v, 1);
    endtask

    task automatic test_mul();
        vec_t v[$];
        v.push_back('{5'd3, 32'h00000002, 32'h00000008, 32'h00000010, 4'b0000});
        v.push_back('{5'd3, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0101});
        v.push_back('{5'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0001});
        v.push_back('{5'd3, 32'h00012345, 32'h00001000, 32'h12345000, 4'b0000});
        run_vectors("mul", v, 33);
    endtask

    task automatic test_div();
        vec_t v[$];
        v.push_back('{5'd5, 32'h00000010, 32'h00000004, 32'h00000004, 4'b0000});
        v.push_back('{5'd5, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 4'b1001});
        v.push_back('{5'd5, 32'hFFFFFFFF, 32'h0000000A, 32'h19999999, 4'b0000});
        v.push_back('{5'd5, 32'h00000003, 32'h00000005, 32'h00000000, 4'b0100});
        v.push_back('{5'd5, 32'h80000000, 32'h00000003, 32'h2AAAAAAA, 4'b0000});
        run_vectors("div", v, 33);
    endtask

    // While stalled in DONE, outputs must hold and new requests must be ignored.
    // That includes the edge on which out_ready and in_valid are both high.
    task automatic test_hold();
        int lat;
        issue(5'd1, 32'd10, 32'd20);
        wait_done(lat);
        @(negedge clk);
        alu_ctrl = 5'd2;
        srcA     = 32'h00000001;
        srcB     = 32'h00000002;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check_count++;
            if ({out_valid, in_ready, result, alu_flags} !== {1'b1, 1'b0, 32'd30, 4'b0000})
                $display("[TB] FAIL hold_cycle%0d: got v=%b r=%b res=%h fl=%b expected v=1 r=0 res=0000001e fl=0000",
                         c, out_valid, in_ready, result, alu_flags);
            else pass_count++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_count++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("[TB] FAIL hold_release_no_accept: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
        else pass_count++;
        check_count++;
        if (result !== 32'd30)
            $display("[TB] FAIL hold_release_result: got %h expected 0000001e", result);
        else pass_count++;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_div();
        int seen = 0;
        issue(5'd5, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_count++;
        if ({in_ready, out_valid, result, alu_flags} !== {1'b1, 1'b0, 32'h0, 4'b0000})
            $display("[TB] FAIL reset_mid_div: got r=%b v=%b res=%h fl=%b expected r=1 v=0 res=00000000 fl=0000",
                     in_ready, out_valid, result, alu_flags);
        else pass_count++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check_count++;
        if (seen !== 0) $display("[TB] FAIL reset_discard: got %0d valid cycles expected 0", seen);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        v.push_back('{5'd1, 32'h00000003, 32'h00000004, 32'h00000007, 4'b0000});
        v.push_back('{5'd2, 32'h00000009, 32'h00000009, 32'h00000000, 4'b0110});
        run_vectors("b2b", v, 1);
    endtask

    initial begin
        test_reset();
        test_simple_ops();
        test_lnum();
        test_undefined();
        test_mul();
        test_div();
        test_hold();
        test_reset_mid_div();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
